// File: rtl/crop_window_if.sv
// crop_window_if: raster pixel input plus cropped, marked pixel output bundle.
interface crop_window_if;
    logic        i_dval;
    logic [9:0]  i_data;
    logic [15:0] i_xstart;
    logic        o_dval;
    logic [9:0]  o_data;
    logic [15:0] o_x;
    logic [15:0] o_y;
    logic        o_sof;
    logic        o_eol;
    logic [15:0] o_xorg;
    modport slave (
        input  i_dval, i_data, i_xstart,
        output o_dval, o_data, o_x, o_y, o_sof, o_eol, o_xorg
    );
    modport master (
        output i_dval, i_data, i_xstart,
        input  o_dval, o_data, o_x, o_y, o_sof, o_eol, o_xorg
    );
endinterface

// File: rtl/crop_window.sv
// crop_window: fixed CROP_W x CROP_H sub-window of a raster stream, X origin reloaded per frame.
// Optional macro CROP_XCLAMP_EN clamps the loaded origin so every window row is complete.
module crop_window #(
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480,
    parameter int CROP_W     = 320,
    parameter int CROP_H     = 240,
    parameter int YSTART     = 120,
    parameter int XSTART_DEF = 160
) (
    input logic          i_clk,
    input logic          i_rst_n,
    crop_window_if.slave bus
);
    typedef enum logic [1:0] {S_VSKIP, S_CROP, S_VTAIL} state_t;
    localparam logic [15:0] LP_XLAST = 16'(H_ACT - 1);
    localparam logic [15:0] LP_YLAST = 16'(V_ACT - 1);
    localparam logic [15:0] LP_YPRE  = 16'(YSTART - 1);
    localparam logic [15:0] LP_YEND  = 16'(YSTART + CROP_H - 1);
    localparam logic [15:0] LP_YS    = 16'(YSTART);
    localparam logic [15:0] LP_XMAX  = 16'(H_ACT - CROP_W);
    localparam state_t      LP_WRAP  = (YSTART == 0) ? S_CROP : S_VSKIP;

    state_t      r_state;
    logic [15:0] r_x, r_y, r_xorg;
    logic        r_dval, r_sof, r_eol;
    logic [9:0]  r_data;
    logic [15:0] r_ox, r_oy;
    logic        w_line_end, w_frame_end, w_emit;
    logic [15:0] w_xload, w_ox;
    logic [16:0] w_xend;

    assign w_line_end  = bus.i_dval && r_x == LP_XLAST;
    assign w_frame_end = w_line_end && r_y == LP_YLAST;
    assign w_xend      = {1'b0, r_xorg} + 17'(CROP_W);
    assign w_ox        = r_x - r_xorg;
    assign w_emit      = bus.i_dval && r_state == S_CROP && r_x >= r_xorg && {1'b0, r_x} < w_xend;
`ifdef CROP_XCLAMP_EN
    assign w_xload = (bus.i_xstart > LP_XMAX) ? LP_XMAX : bus.i_xstart;
`else
    assign w_xload = bus.i_xstart;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= LP_WRAP;
            r_x     <= '0;
            r_y     <= '0;
            r_xorg  <= 16'(XSTART_DEF);
            r_dval  <= 1'b0;
            r_data  <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
        end else begin
            if (bus.i_dval) begin
                r_x <= w_line_end ? '0 : r_x + 16'd1;
                if (w_line_end)
                    r_y <= w_frame_end ? '0 : r_y + 16'd1;
            end
            if (w_frame_end)
                r_xorg <= w_xload;
            // Frame wrap takes priority so a window ending on the last line never strands the FSM.
            if (w_frame_end)
                r_state <= LP_WRAP;
            else if (w_line_end && r_state == S_VSKIP && r_y == LP_YPRE)
                r_state <= S_CROP;
            else if (w_line_end && r_state == S_CROP && r_y == LP_YEND)
                r_state <= S_VTAIL;
            r_dval <= w_emit;
            r_sof  <= w_emit && w_ox == '0 && r_y == LP_YS;
            r_eol  <= w_emit && w_ox == 16'(CROP_W - 1);
            if (w_emit) begin
                r_data <= bus.i_data;
                r_ox   <= w_ox;
                r_oy   <= r_y - LP_YS;
            end
        end
    end

    assign bus.o_dval = r_dval;
    assign bus.o_data = r_data;
    assign bus.o_x    = r_ox;
    assign bus.o_y    = r_oy;
    assign bus.o_sof  = r_sof;
    assign bus.o_eol  = r_eol;
    assign bus.o_xorg = r_xorg;
endmodule

// File: tb/tb_crop_window.sv
// tb_crop_window: randomized pixel data on a scaled raster, checked against a window-rule model.
module tb_crop_window;
    localparam int H = 16, V = 12, CW = 8, CH = 6, YS = 3, XDEF = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   chk = 0, fails = 0;
    int   mx = 0, my = 0, morg = XDEF;
    int   e_x = 0, e_y = 0, e_data = 0;
    logic e_dval = 1'b0, e_sof = 1'b0, e_eol = 1'b0;
    int   n_px = 0, n_eol = 0;
    logic [60:0] act, exp_v;

    crop_window_if bus ();
    crop_window #(.H_ACT(H), .V_ACT(V), .CROP_W(CW), .CROP_H(CH), .YSTART(YS), .XSTART_DEF(XDEF))
        dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int clampx(int xs);
`ifdef CROP_XCLAMP_EN
        return (xs > H - CW) ? H - CW : xs;
`else
        return xs;
`endif
    endfunction

    function automatic int row_px(int org);
        return (org >= H) ? 0 : ((org + CW > H) ? H - org : CW);
    endfunction

    task automatic step(input logic dv, input logic rn);
        @(negedge clk);
        act   = {bus.o_dval, bus.o_data, bus.o_x, bus.o_y, bus.o_sof, bus.o_eol, bus.o_xorg};
        exp_v = {e_dval, 10'(e_data), 16'(e_x), 16'(e_y), e_sof, e_eol, 16'(morg)};
        chk++;
        assert (act === exp_v) else begin
            fails++;
            $error("FAIL out_bundle at raster x=%0d y=%0d: observed=%h expected=%h", mx, my, act, exp_v);
        end
        if (bus.o_dval) n_px++;
        if (bus.o_eol) n_eol++;
        rst_n       = rn;
        bus.i_dval  = dv;
        bus.i_data  = 10'($urandom);
        if (!rn) begin
            {e_dval, e_sof, e_eol} = 3'b000;
            e_data = 0; e_x = 0; e_y = 0;
            mx = 0; my = 0; morg = XDEF;
        end else begin
            e_dval = dv && my >= YS && my < YS + CH && mx >= morg && mx < morg + CW;
            if (e_dval) begin
                e_data = int'(bus.i_data);
                e_x = mx - morg;
                e_y = my - YS;
            end
            e_sof = e_dval && e_x == 0 && e_y == 0;
            e_eol = e_dval && e_x == CW - 1;
            if (dv) begin
                if (mx == H - 1) begin
                    mx = 0;
                    if (my == V - 1) begin
                        my = 0;
                        morg = clampx(int'(bus.i_xstart));
                    end else my++;
                end else mx++;
            end
        end
    endtask

    task automatic pixels(input int n, input logic toggle);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1);
            if (toggle) step(1'b0, 1'b1);
        end
    endtask

    task automatic frame_counts(input logic toggle, input string tag);
        int org;
        org = morg;
        n_px = 0; n_eol = 0;
        pixels(H * V, toggle);
        step(1'b0, 1'b1);
        chk++;
        assert (n_px == row_px(org) * CH) else begin
            fails++;
            $error("FAIL %s_pixels: observed=%0d expected=%0d", tag, n_px, row_px(org) * CH);
        end
        chk++;
        assert (n_eol == ((org + CW <= H) ? CH : 0)) else begin
            fails++;
            $error("FAIL %s_eols: observed=%0d expected=%0d", tag, n_eol, (org + CW <= H) ? CH : 0);
        end
    endtask

    initial begin
        bus.i_dval = 1'b0;
        bus.i_data = '0;
        bus.i_xstart = 16'd5;
        @(posedge clk);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        frame_counts(1'b0, "frame1_default");
        frame_counts(1'b0, "frame2_org5");
        frame_counts(1'b1, "toggled_dval");
        bus.i_xstart = 16'd13;
        frame_counts(1'b0, "pre_none_found");
        bus.i_xstart = 16'd5;
        frame_counts(1'b0, "none_found");
        frame_counts(1'b0, "back_to_5");
        pixels(H * (YS + 2) + 3, 1'b0);
        bus.i_xstart = 16'd7;
        pixels(H * V - (H * (YS + 2) + 3), 1'b0);
        frame_counts(1'b0, "midframe_change");
        while (!(my == YS + 1 && mx == 9)) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        frame_counts(1'b0, "after_reset");
        frame_counts(1'b1, "after_reset_toggled");
        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end
endmodule
